// File: rtl/brd_wb2ps_wc_tagmem_pkg.sv
// Shared definitions for the PSRAM bridge write cache tag store: geometry,
// address field bounds, tag-entry layout and the tree-PLRU touch function.
package brd_wb2ps_wc_tagmem_pkg;

  localparam int WC_WAYS    = 4;
  localparam int WC_LINES   = 16;
  localparam int WC_TAG_W   = 13;

  localparam int WC_TAG_HI  = 22;
  localparam int WC_TAG_LO  = 10;
  localparam int WC_LINE_HI = 9;
  localparam int WC_LINE_LO = 6;
  localparam int WC_OFF_HI  = 5;
  localparam int WC_OFF_LO  = 0;

  typedef logic [1:0]          way_t;
  typedef logic [3:0]          line_t;
  typedef logic [WC_TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    logic dirty;
    tag_t tag;
  } tag_entry_t;

  // b0 chooses pair {0,1}/{2,3}, b1 inside {0,1}, b2 inside {2,3}; 0 = lower side.
  function automatic logic [2:0] plru_touch(input logic [2:0] plru, input way_t way);
    logic [2:0] nxt;
    nxt = plru;
    case (way)
      2'd0:    begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
      2'd1:    begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
      2'd2:    begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
      default: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/brd_wb2ps_wc_tagmem_if.sv
// Request/response bundle between the Wishbone entry stage, tag-init sequencer,
// refill engine (master side) and the tag store (slave side).
interface brd_wb2ps_wc_tagmem_if;
  import brd_wb2ps_wc_tagmem_pkg::*;

  logic                         taginit_en;
  logic [WC_LINE_HI:WC_LINE_LO] taginit_lineno;
  logic                         lookup_req;
  logic                         lookup_we;
  logic [WC_TAG_HI:WC_LINE_LO]  lookup_adr;
  logic                         lookup_ack;
  logic                         hit;
  logic [1:0]                   hit_way;
  logic [1:0]                   victim_way;
  logic                         victim_dirty;
  logic [WC_TAG_HI:WC_TAG_LO]   victim_tag;
  logic                         fill_req;
  logic [1:0]                   fill_way;
  logic [WC_TAG_HI:WC_LINE_LO]  fill_adr;
  logic                         fill_dirty;

  modport master (
    output taginit_en, taginit_lineno, lookup_req, lookup_we, lookup_adr,
           fill_req, fill_way, fill_adr, fill_dirty,
    input  lookup_ack, hit, hit_way, victim_way, victim_dirty, victim_tag
  );

  modport slave (
    input  taginit_en, taginit_lineno, lookup_req, lookup_we, lookup_adr,
           fill_req, fill_way, fill_adr, fill_dirty,
    output lookup_ack, hit, hit_way, victim_way, victim_dirty, victim_tag
  );

endinterface

// File: rtl/brd_wb2ps_wc_plru.sv
// Combinational tree-PLRU: victim choice for the looked-up line and next-state
// for both the lookup-hit and fill accesses.
module brd_wb2ps_wc_plru
  import brd_wb2ps_wc_tagmem_pkg::*;
(
  input  logic [2:0] lu_plru_i,
  input  logic [3:0] lu_valid_i,
  input  way_t       lu_way_i,
  input  logic [2:0] fill_plru_i,
  input  way_t       fill_way_i,
  output way_t       victim_way_o,
  output logic [2:0] lu_plru_o,
  output logic [2:0] fill_plru_o
);

  // Lowest invalid way first; only a full line falls back to the tree.
  always_comb begin
    victim_way_o = 2'd0;
    casez (lu_valid_i)
      4'b???0: victim_way_o = 2'd0;
      4'b??01: victim_way_o = 2'd1;
      4'b?011: victim_way_o = 2'd2;
      4'b0111: victim_way_o = 2'd3;
      default: begin
        if (lu_plru_i[0]) begin
          victim_way_o = {1'b1, lu_plru_i[2]};
        end else begin
          victim_way_o = {1'b0, lu_plru_i[1]};
        end
      end
    endcase
  end

  assign lu_plru_o   = plru_touch(lu_plru_i, lu_way_i);
  assign fill_plru_o = plru_touch(fill_plru_i, fill_way_i);

endmodule

// File: rtl/brd_wb2ps_wc_tagmem.sv
// 4-way x 16-line tag store with hit/miss lookup and tree-PLRU replacement.
// Define WC_DIRTY_EN for write-back (dirty tracking); otherwise write-through.
module brd_wb2ps_wc_tagmem
  import brd_wb2ps_wc_tagmem_pkg::*;
#(
  parameter int TAG_W = WC_TAG_W,
  parameter int WAYS  = WC_WAYS
) (
  input logic                   cpuclk,
  input logic                   WSHRST,
  brd_wb2ps_wc_tagmem_if.slave  bus_if
);

  // Unreset storage so it can map onto distributed RAM.
  logic [TAG_W-1:0] tag_q   [WC_LINES][WAYS];
  logic [WAYS-1:0]  valid_q [WC_LINES];
  logic [2:0]       plru_q  [WC_LINES];
`ifdef WC_DIRTY_EN
  logic [WAYS-1:0]  dirty_q [WC_LINES];
  logic             lu_dirty_we_s;
`else
  logic             unused_s;
  assign unused_s = ^{bus_if.lookup_we, bus_if.fill_dirty};
`endif

  line_t            lu_idx_s, fill_idx_s;
  logic [TAG_W-1:0] lu_tag_s;
  tag_entry_t       ent_s [WAYS];
  tag_entry_t       vict_ent_s;
  logic [WAYS-1:0]  match_s;
  logic             hit_s;
  way_t             hit_way_s, victim_way_s;
  logic [2:0]       lu_plru_nxt_s, fill_plru_nxt_s;
  logic             lu_hit_s, fill_ok_s, fill_same_s, lu_plru_we_s;

  logic             ack_q, ack_d, hit_q, hit_d, vdirty_q, vdirty_d;
  way_t             hit_way_q, hit_way_d, vway_q, vway_d;
  logic [TAG_W-1:0] vtag_q, vtag_d;

  assign lu_idx_s   = bus_if.lookup_adr[WC_LINE_HI:WC_LINE_LO];
  assign lu_tag_s   = bus_if.lookup_adr[WC_TAG_HI:WC_TAG_LO];
  assign fill_idx_s = bus_if.fill_adr[WC_LINE_HI:WC_LINE_LO];

  // Read the addressed line and compare tags in every way.
  always_comb begin
    match_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      ent_s[w].valid = valid_q[lu_idx_s][w];
`ifdef WC_DIRTY_EN
      ent_s[w].dirty = dirty_q[lu_idx_s][w];
`else
      ent_s[w].dirty = 1'b0;
`endif
      ent_s[w].tag   = tag_t'(tag_q[lu_idx_s][w]);
      match_s[w]     = ent_s[w].valid && (ent_s[w].tag == tag_t'(lu_tag_s));
    end
  end

  // Lowest matching way wins should more than one ever match.
  always_comb begin
    hit_way_s = 2'd0;
    casez (match_s)
      4'b???1: hit_way_s = 2'd0;
      4'b??10: hit_way_s = 2'd1;
      4'b?100: hit_way_s = 2'd2;
      4'b1000: hit_way_s = 2'd3;
      default: hit_way_s = 2'd0;
    endcase
  end

  assign hit_s      = |match_s;
  assign vict_ent_s = ent_s[victim_way_s];

  brd_wb2ps_wc_plru u_plru (
    .lu_plru_i    (plru_q[lu_idx_s]),
    .lu_valid_i   (valid_q[lu_idx_s]),
    .lu_way_i     (hit_way_s),
    .fill_plru_i  (plru_q[fill_idx_s]),
    .fill_way_i   (bus_if.fill_way),
    .victim_way_o (victim_way_s),
    .lu_plru_o    (lu_plru_nxt_s),
    .fill_plru_o  (fill_plru_nxt_s)
  );

  // Arbitrate updates: init beats fill, fill beats lookup on the same line.
  always_comb begin
    lu_hit_s     = bus_if.lookup_req && !bus_if.taginit_en && hit_s;
    fill_ok_s    = bus_if.fill_req &&
                   !(bus_if.taginit_en && (bus_if.taginit_lineno == fill_idx_s));
    fill_same_s  = fill_ok_s && (fill_idx_s == lu_idx_s);
    lu_plru_we_s = lu_hit_s && !fill_same_s;
`ifdef WC_DIRTY_EN
    lu_dirty_we_s = lu_hit_s && bus_if.lookup_we &&
                    !(fill_same_s && (bus_if.fill_way == hit_way_s));
`endif
  end

  // Storage write port: init clear, fill, and lookup-side PLRU/dirty updates.
  always_ff @(posedge cpuclk) begin
    if (bus_if.taginit_en) begin
      valid_q[bus_if.taginit_lineno] <= '0;
      plru_q[bus_if.taginit_lineno]  <= 3'b000;
`ifdef WC_DIRTY_EN
      dirty_q[bus_if.taginit_lineno] <= '0;
`endif
    end
    if (fill_ok_s) begin
      tag_q[fill_idx_s][bus_if.fill_way]   <= bus_if.fill_adr[WC_TAG_HI:WC_TAG_LO];
      valid_q[fill_idx_s][bus_if.fill_way] <= 1'b1;
      plru_q[fill_idx_s]                   <= fill_plru_nxt_s;
`ifdef WC_DIRTY_EN
      dirty_q[fill_idx_s][bus_if.fill_way] <= bus_if.fill_dirty;
`endif
    end
    if (lu_plru_we_s) begin
      plru_q[lu_idx_s] <= lu_plru_nxt_s;
    end
`ifdef WC_DIRTY_EN
    if (lu_dirty_we_s) begin
      dirty_q[lu_idx_s][hit_way_s] <= 1'b1;
    end
`endif
  end

  // Result registers load on each lookup and otherwise hold.
  always_comb begin
    ack_d     = bus_if.lookup_req;
    hit_d     = hit_q;
    hit_way_d = hit_way_q;
    vway_d    = vway_q;
    vdirty_d  = vdirty_q;
    vtag_d    = vtag_q;
    if (bus_if.lookup_req && bus_if.taginit_en) begin
      hit_d     = 1'b0;
      hit_way_d = 2'd0;
      vway_d    = 2'd0;
      vdirty_d  = 1'b0;
      vtag_d    = '0;
    end else if (bus_if.lookup_req) begin
      hit_d     = hit_s;
      hit_way_d = hit_way_s;
      vway_d    = victim_way_s;
      vdirty_d  = vict_ent_s.valid && vict_ent_s.dirty;
      vtag_d    = vict_ent_s.tag;
    end else begin
      ack_d     = 1'b0;
    end
  end

  // Output register bank.
  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) begin
      ack_q     <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= 2'd0;
      vway_q    <= 2'd0;
      vdirty_q  <= 1'b0;
      vtag_q    <= '0;
    end else begin
      ack_q     <= ack_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
      vway_q    <= vway_d;
      vdirty_q  <= vdirty_d;
      vtag_q    <= vtag_d;
    end
  end

  assign bus_if.lookup_ack   = ack_q;
  assign bus_if.hit          = hit_q;
  assign bus_if.hit_way      = hit_way_q;
  assign bus_if.victim_way   = vway_q;
  assign bus_if.victim_dirty = vdirty_q;
  assign bus_if.victim_tag   = vtag_q;

endmodule

// File: tb/tb_brd_wb2ps_wc_tagmem.sv
// Scoreboard bench for brd_wb2ps_wc_tagmem: directed stimulus pushes expected
// lookup results, a monitor pops and compares on every lookup_ack.
module tb_brd_wb2ps_wc_tagmem;
  import brd_wb2ps_wc_tagmem_pkg::*;

`ifdef WC_DIRTY_EN
  localparam logic DIRTY_ON = 1'b1;
`else
  localparam logic DIRTY_ON = 1'b0;
`endif

  typedef struct {
    logic        hit;
    logic [1:0]  way;
    logic        chk_vd;
    logic        vd;
    logic        chk_vt;
    logic [12:0] vt;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  brd_wb2ps_wc_tagmem_if bus ();

  brd_wb2ps_wc_tagmem dut (
    .cpuclk (clk),
    .WSHRST (rst),
    .bus_if (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] la(input logic [12:0] tag, input logic [3:0] line);
    return {tag, line};
  endfunction

  function automatic logic [16:0] ba2la(input logic [31:0] ba);
    logic [31:0] t;
    t = ba >> (WC_OFF_HI - WC_OFF_LO + 1);
    return t[16:0];
  endfunction

  task automatic exp_lu(input logic h, input logic [1:0] w, input logic cvd, input logic vd,
                        input logic cvt, input logic [12:0] vt);
    exp_t e;
    e.hit = h; e.way = w; e.chk_vd = cvd; e.vd = vd; e.chk_vt = cvt; e.vt = vt;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // One clock of stimulus, starting and ending on a falling edge.
  task automatic drive(input logic f, input logic [1:0] fw, input logic [16:0] fa, input logic fd,
                       input logic l, input logic [16:0] lad, input logic lw);
    bus.fill_req = f; bus.fill_way = fw; bus.fill_adr = fa; bus.fill_dirty = fd;
    bus.lookup_req = l; bus.lookup_adr = lad; bus.lookup_we = lw;
    @(negedge clk);
    bus.fill_req = 1'b0; bus.lookup_req = 1'b0; bus.lookup_we = 1'b0; bus.fill_dirty = 1'b0;
  endtask

  task automatic fill(input logic [1:0] w, input logic [16:0] a, input logic d);
    drive(1'b1, w, a, d, 1'b0, 17'h0, 1'b0);
  endtask

  task automatic lookup(input logic [16:0] a, input logic we);
    drive(1'b0, 2'd0, 17'h0, 1'b0, 1'b1, a, we);
  endtask

  task automatic run_init(input bit with_lu);
    for (int i = 0; i < WC_LINES; i++) begin
      bus.taginit_en = 1'b1;
      bus.taginit_lineno = 4'(i);
      if (with_lu && i == 4) begin
        exp_lu(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 13'h0);
        bus.lookup_req = 1'b1;
        bus.lookup_adr = 17'h00001;
      end
      @(negedge clk);
      bus.lookup_req = 1'b0;
    end
    bus.taginit_en = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"},   32'(bus.lookup_ack),   32'h0);
    check({tag, "_hit"},   32'(bus.hit),          32'h0);
    check({tag, "_hway"},  32'(bus.hit_way),      32'h0);
    check({tag, "_vway"},  32'(bus.victim_way),   32'h0);
    check({tag, "_vdirty"},32'(bus.victim_dirty), 32'h0);
    check({tag, "_vtag"},  32'(bus.victim_tag),   32'h0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.lookup_ack === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("hit", 32'(bus.hit), 32'(e.hit));
          if (e.hit) check("hit_way", 32'(bus.hit_way), 32'(e.way));
          else       check("victim_way", 32'(bus.victim_way), 32'(e.way));
          if (e.chk_vd) check("victim_dirty", 32'(bus.victim_dirty), 32'(e.vd));
          if (e.chk_vt) check("victim_tag", 32'(bus.victim_tag), 32'(e.vt));
        end
      end
    end
  endtask

  initial begin
    bus.taginit_en = 1'b0; bus.taginit_lineno = 4'h0;
    bus.lookup_req = 1'b0; bus.lookup_we = 1'b0; bus.lookup_adr = 17'h0;
    bus.fill_req = 1'b0; bus.fill_way = 2'd0; bus.fill_adr = 17'h0; bus.fill_dirty = 1'b0;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Init sweep with a lookup landing on an init cycle, then a plain miss.
    run_init(1'b1);
    exp_lu(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 13'h0);
    lookup(ba2la(32'h0000_0040), 1'b0);

    // Fill then hit on line 5.
    fill(2'd2, 17'h12345, 1'b0);
    exp_lu(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 13'h0);
    lookup(17'h12345, 1'b0);

    // Invalid-first victim on line 3.
    fill(2'd0, la(13'h100, 4'd3), 1'b0);
    fill(2'd1, la(13'h101, 4'd3), 1'b0);
    exp_lu(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 13'h0);
    lookup(la(13'h102, 4'd3), 1'b0);

    // Tree-PLRU on line 7, including back-to-back lookups.
    for (int w = 0; w < 4; w++) fill(2'(w), la(13'h200 + 13'(w), 4'd7), 1'b0);
    exp_lu(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 13'h0);
    lookup(la(13'h200, 4'd7), 1'b0);
    exp_lu(1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 13'h202);
    lookup(la(13'h2FF, 4'd7), 1'b0);
    exp_lu(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 13'h0);
    lookup(la(13'h202, 4'd7), 1'b0);
    exp_lu(1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 13'h201);
    lookup(la(13'h2FE, 4'd7), 1'b0);

    // Write hit marks way 1 of line 9 dirty, then it becomes the victim.
    fill(2'd1, la(13'h301, 4'd9), 1'b0);
    exp_lu(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 13'h0);
    lookup(la(13'h301, 4'd9), 1'b1);
    fill(2'd0, la(13'h300, 4'd9), 1'b0);
    fill(2'd2, la(13'h302, 4'd9), 1'b0);
    fill(2'd3, la(13'h303, 4'd9), 1'b0);
    exp_lu(1'b0, 2'd1, 1'b1, DIRTY_ON, 1'b1, 13'h301);
    lookup(la(13'h3FF, 4'd9), 1'b0);

    // Same-cycle fill and lookup of a new address: read-before-write.
    exp_lu(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 13'h0);
    drive(1'b1, 2'd0, la(13'h555, 4'd11), 1'b0, 1'b1, la(13'h555, 4'd11), 1'b0);
    exp_lu(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 13'h0);
    lookup(la(13'h555, 4'd11), 1'b0);

    // Hit and fill on one line in one cycle: only the fill moves the PLRU.
    for (int w = 0; w < 4; w++) fill(2'(w), la(13'h600 + 13'(w), 4'd13), 1'b0);
    exp_lu(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 13'h0);
    drive(1'b1, 2'd3, la(13'h6AA, 4'd13), 1'b0, 1'b1, la(13'h600, 4'd13), 1'b0);
    exp_lu(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 13'h600);
    lookup(la(13'h6FF, 4'd13), 1'b0);

    // Reset in mid-operation clears the outputs; storage needs a fresh init.
    exp_lu(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 13'h0);
    lookup(17'h12345, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_init(1'b0);
    exp_lu(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 13'h0);
    lookup(17'h12345, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
